// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - opcode/ALU constants and shared decode types for the decode stage
package decode_pkg;

    localparam logic [6:0] OP_R   = 7'h33;
    localparam logic [6:0] OP_I   = 7'h13;
    localparam logic [6:0] OP_LUI = 7'h37;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_SUB  = 4'b0100,
        ALU_SLT  = 4'b0101,
        ALU_XOR  = 4'b0110,
        ALU_SLTU = 4'b0111,
        ALU_SRL  = 4'b1000,
        ALU_SRA  = 4'b1001,
        ALU_INV  = 4'b1111
    } alu_t;

    // XLEN-independent part of a decoded entry; the immediate is added by the
    // using module's decoded_t typedef so this package stays unparametrised.
    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        alu_t       alu_ctrl;
        logic       use_imm;
        logic       reg_write;
        logic       illegal;
    } decoded_ctrl_t;

    localparam decoded_ctrl_t CTRL_ILLEGAL = '{
        rs1: 5'd0, rs2: 5'd0, rd: 5'd0, alu_ctrl: ALU_INV,
        use_imm: 1'b0, reg_write: 1'b0, illegal: 1'b1
    };

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_t;

endpackage

// File: rtl/decode_if.sv
// rtl/decode_if.sv - fetch-side and execute-side handshake bundle of the decode stage
interface decode_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [4:0]      out_rd;
    logic [XLEN-1:0] out_imm;
    logic [3:0]      out_alu_ctrl;
    logic            out_use_imm;
    logic            out_reg_write;
    logic            out_illegal;

    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd,
               out_imm, out_alu_ctrl, out_use_imm, out_reg_write, out_illegal
    );

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd,
               out_imm, out_alu_ctrl, out_use_imm, out_reg_write, out_illegal
    );
endinterface

// File: rtl/decode_comb.sv
// rtl/decode_comb.sv - combinational RV32I/RV64I integer ALU decoder (R-type, I-type, LUI)
module decode_comb
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output decoded_ctrl_t   ctrl,
    output logic [XLEN-1:0] imm
);
    localparam int SHW = $clog2(XLEN);
    localparam int UPW = 12 - SHW;
    // srai marker sits at instruction bit 30 whatever the shamt width is
    localparam logic [UPW-1:0] SRAI_UP = UPW'(7'h20 >> (SHW - 5));

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [UPW-1:0]  upper;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_sh;
    logic [XLEN-1:0] imm_u;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];
    assign upper  = inst[31:20+SHW];
    assign imm_i  = XLEN'($signed(inst[31:20]));
    assign imm_sh = XLEN'(inst[20 +: SHW]);
    assign imm_u  = XLEN'($signed({inst[31:12], 12'b0}));

    alu_t            op;
    logic            ok;
    logic [XLEN-1:0] imm_sel;

    always_comb begin
        ctrl    = CTRL_ILLEGAL;
        imm     = '0;
        op      = ALU_INV;
        ok      = 1'b0;
        imm_sel = '0;
        case (opcode)
            OP_R: begin
                ok = 1'b1;
                case ({funct7, funct3})
                    {7'h00, 3'd0}: op = ALU_ADD;
                    {7'h20, 3'd0}: op = ALU_SUB;
                    {7'h00, 3'd1}: op = ALU_SLL;
                    {7'h00, 3'd2}: op = ALU_SLT;
                    {7'h00, 3'd3}: op = ALU_SLTU;
                    {7'h00, 3'd4}: op = ALU_XOR;
                    {7'h00, 3'd5}: op = ALU_SRL;
                    {7'h20, 3'd5}: op = ALU_SRA;
                    {7'h00, 3'd6}: op = ALU_OR;
                    {7'h00, 3'd7}: op = ALU_AND;
                    default:       ok = 1'b0;
                endcase
                if (ok) begin
                    ctrl = '{rs1: inst[19:15], rs2: inst[24:20], rd: inst[11:7],
                             alu_ctrl: op, use_imm: 1'b0, reg_write: 1'b1, illegal: 1'b0};
                end
            end
            OP_I: begin
                ok      = 1'b1;
                imm_sel = imm_i;
                case (funct3)
                    3'd0: op = ALU_ADD;
                    3'd2: op = ALU_SLT;
                    3'd3: op = ALU_SLTU;
                    3'd4: op = ALU_XOR;
                    3'd6: op = ALU_OR;
                    3'd7: op = ALU_AND;
                    3'd1: begin
                        op      = ALU_SLL;
                        imm_sel = imm_sh;
                        ok      = (upper == '0);
                    end
                    default: begin
                        imm_sel = imm_sh;
                        if (upper == '0) begin
                            op = ALU_SRL;
                        end else if (upper == SRAI_UP) begin
                            op = ALU_SRA;
                        end else begin
                            ok = 1'b0;
                        end
                    end
                endcase
                if (ok) begin
                    ctrl = '{rs1: inst[19:15], rs2: 5'd0, rd: inst[11:7],
                             alu_ctrl: op, use_imm: 1'b1, reg_write: 1'b1, illegal: 1'b0};
                    imm  = imm_sel;
                end
            end
            OP_LUI: begin
                ctrl = '{rs1: 5'd0, rs2: 5'd0, rd: inst[11:7],
                         alu_ctrl: ALU_ADD, use_imm: 1'b1, reg_write: 1'b1, illegal: 1'b0};
                imm  = imm_u;
            end
            default: begin
                ctrl = CTRL_ILLEGAL;
            end
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered decode stage with 2-entry skid buffer and illegal counter
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    decode_if.slave          bus,
    output logic [CNT_W-1:0] illegal_cnt
);
    typedef struct packed {
        logic [XLEN-1:0] imm;
        decoded_ctrl_t   ctrl;
    } decoded_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        decoded_t        dec;
    } entry_t;

    decoded_ctrl_t   dec_ctrl;
    logic [XLEN-1:0] dec_imm;
    entry_t          new_e;

    decode_comb #(.XLEN(XLEN)) u_comb (
        .inst (bus.in_inst),
        .ctrl (dec_ctrl),
        .imm  (dec_imm)
    );

    assign new_e = '{pc: bus.in_pc, dec: '{imm: dec_imm, ctrl: dec_ctrl}};

    buf_state_t state;
    entry_t     main_q;
    entry_t     skid_q;
    logic       ready_q;
    logic       valid_q;
    logic       accept;
    logic       drain;

    assign accept = bus.in_valid & ready_q;
    assign drain  = valid_q & bus.out_ready;

    // in_ready/out_valid are flops that always track the next state, so
    // neither depends combinationally on in_valid or out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BUF_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            ready_q     <= 1'b1;
            valid_q     <= 1'b0;
            illegal_cnt <= '0;
        end else if (flush) begin
            state   <= BUF_EMPTY;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            if (accept && new_e.dec.ctrl.illegal && (illegal_cnt != '1)) begin
                illegal_cnt <= illegal_cnt + 1'b1;
            end
            case (state)
                BUF_EMPTY: begin
                    if (accept) begin
                        main_q  <= new_e;
                        state   <= BUF_ONE;
                        valid_q <= 1'b1;
                    end
                end
                BUF_ONE: begin
                    if (accept && drain) begin
                        main_q <= new_e;
                    end else if (accept) begin
                        skid_q  <= new_e;
                        state   <= BUF_TWO;
                        ready_q <= 1'b0;
                    end else if (drain) begin
                        state   <= BUF_EMPTY;
                        valid_q <= 1'b0;
                    end
                end
                BUF_TWO: begin
                    if (drain) begin
                        main_q  <= skid_q;
                        state   <= BUF_ONE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= BUF_EMPTY;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready      = ready_q;
    assign bus.out_valid     = valid_q;
    assign bus.out_pc        = main_q.pc;
    assign bus.out_imm       = main_q.dec.imm;
    assign bus.out_rs1       = main_q.dec.ctrl.rs1;
    assign bus.out_rs2       = main_q.dec.ctrl.rs2;
    assign bus.out_rd        = main_q.dec.ctrl.rd;
    assign bus.out_alu_ctrl  = main_q.dec.ctrl.alu_ctrl;
    assign bus.out_use_imm   = main_q.dec.ctrl.use_imm;
    assign bus.out_reg_write = main_q.dec.ctrl.reg_write;
    assign bus.out_illegal   = main_q.dec.ctrl.illegal;

endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised, registered instruction-decode stage for the RV32I/RV64I datapath. It extends the existing ALU encoding to the full R-type and I-type integer sets plus LUI, flags illegal encodings, and keeps a saturating illegal-instruction counter. A ready/valid handshake with a 2-entry skid buffer sits between fetch and execute, giving full throughput under backpressure.

## Interface
- XLEN, 32: datapath width, 32 or 64; sets the immediate width and SHW = log2(XLEN) shamt bits.
- CNT_W, 16: width of the illegal-instruction counter.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous; drops all buffered entries.
- in_valid  in  1  fetch offers an instruction.
- in_ready  out  1  stage can accept; registered.
- in_inst  in  32  instruction word.
- in_pc  in  XLEN  instruction address.
- out_valid  out  1  decoded entry available.
- out_ready  in  1  execute accepts the entry.
- out_pc  out  XLEN  pc of the entry.
- out_rs1, out_rs2, out_rd  out  5  register numbers.
- out_imm  out  XLEN  sign-extended immediate.
- out_alu_ctrl  out  4  ALU op code.
- out_use_imm  out  1  operand B is out_imm.
- out_reg_write  out  1  rd is written.
- out_illegal  out  1  unsupported encoding.
- illegal_cnt  out  CNT_W  saturating count of illegal entries accepted.

## Operation
- ALU codes: and 0000, sll 0001, add 0010, or 0011, sub 0100, slt 0101, xor 0110, sltu 0111, srl 1000, sra 1001, invalid 1111.
- Opcode 0x33 (R-type): funct3/funct7 pairs (0,0) add, (0,0x20) sub, (1,0) sll, (2,0) slt, (3,0) sltu, (4,0) xor, (5,0) srl, (5,0x20) sra, (6,0) or, (7,0) and.
  - out_use_imm=0, out_reg_write=1, out_imm=0.
  - Any other pair is illegal.
- Opcode 0x13 (I-type): addi, slti, sltiu, xori, ori, andi take imm = sext(inst[31:20]).
  - slli/srli/srai: imm = zero-extended inst[20+SHW-1:20].
  - inst[31:20+SHW] must be 0, or 0x20 >> (SHW-5) for srai; any other value is illegal.
  - out_rs2=0, out_use_imm=1, out_reg_write=1.
- Opcode 0x37 (LUI): imm = sext({inst[31:12], 12'b0}); out_rs1=0, out_rs2=0, alu add, out_use_imm=1, out_reg_write=1.
- Illegal, including every other opcode: out_illegal=1, alu 1111, rs1/rs2/rd/imm=0, out_reg_write=0, out_use_imm=0. The entry still flows downstream.
- Buffer FSM:
  - EMPTY: in_ready=1, out_valid=0.
  - ONE: main register valid; in_ready=1.
  - TWO: main and skid registers valid; in_ready=0.
- Transitions, evaluated when flush=0:
  - EMPTY→ONE on accept.
  - ONE→TWO on accept without drain.
  - ONE→EMPTY on drain without accept.
  - ONE stays ONE on simultaneous accept and drain.
  - TWO→ONE on drain; skid moves to main.
- Accept = in_valid & in_ready. Drain = out_valid & out_ready.
- Order is strictly FIFO.
- flush=1 forces EMPTY next cycle. Any same-cycle accept is discarded and does not count.
- illegal_cnt increments on accept of an illegal entry, saturates at all-ones, and is not cleared by flush.

## Timing
- Reset values: state EMPTY, out_valid=0, in_ready=1, illegal_cnt=0, all data outputs 0.
- Latency: an instruction accepted at edge N appears on out_* after edge N, when no older entry is pending.
- Throughput: 1 instruction/cycle with out_ready held at 1.
- Under backpressure the stage absorbs exactly 2 entries.
- All outputs are registered; no combinational in→out path, including in_ready.
- Reset mid-operation drops entries immediately. The first accept after rst_n rises is a fresh stream.

## Structure
- Package decode_pkg holds:
  - opcode constants OP_R 0x33, OP_I 0x13, OP_LUI 0x37;
  - ALU code constants;
  - the decoded_t struct (rs1, rs2, rd, imm, alu_ctrl, use_imm, reg_write, illegal), parametrised by XLEN through a typedef in the using module.
- Sub-module decode_comb: purely combinational inst → decoded_t, parametrised by XLEN.
- decode_stage holds the FSM, the two registers and the counter.

## Test plan
- add x3,x1,x2 (0x002081B3) → rs1=1, rs2=2, rd=3, alu 0010, use_imm=0, reg_write=1, illegal=0, out_valid one cycle after accept.
- sub 0x407302B3 → alu 0100, rd=5. srai 0x40315113 → alu 1001, imm=3, use_imm=1.
- addi x1,x0,-1 (0xFFF00093) → imm=0xFFFFFFFF. lui 0x12345237 → rd=4, imm=0x12345000.
  - With XLEN=64, lui 0x80000237 → imm=0xFFFFFFFF80000000.
- XLEN=32: slli 0x02009093 → illegal=1, alu 1111, reg_write=0, illegal_cnt=1.
  - Opcode 0x03 → illegal.
  - With CNT_W=2, 5 illegal instructions → illegal_cnt=3.
- out_ready=0 with 3 back-to-back valid instructions → 2 accepted, in_ready=0 on the third; release out_ready → outputs in order with no loss or duplication.
- State TWO plus flush and in_valid=1 in the same cycle → next cycle out_valid=0, in_ready=1, illegal_cnt unchanged. Async reset mid-stream → all outputs return to reset values.
